// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush scheduler and PC redirect owner for the 5-stage pipe.
// Optional perf counters are compiled in with `define HAZARD_PERF_EN.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   ireq_busy         instruction fetch outstanding
//   dreq_valid        MEM stage holds a load/store request
//   dresp_ok          data memory response this cycle
//   mc_start, mc_len  EX begins a multi-cycle op of mc_len total cycles
//   load_use          ID depends on the load currently in EX
//   redirect_req/pc   EX resolved a mispredict/jump and its target
//   stallF/D/E/M      hold PC, IF/ID, ID/EX, EX/MEM
//   flushD/E/M        bubble into IF/ID, ID/EX, MEM/WB
//   pc_sel, pc_target PC load request and its address
//   perf_stall_cyc    (HAZARD_PERF_EN) cycles with stallF
//   perf_flush_cnt    (HAZARD_PERF_EN) cycles with flushE
module hazard_ctrl #(
    parameter int PC_W = 64,
    parameter int MC_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ireq_busy,
    input  logic            dreq_valid,
    input  logic            dresp_ok,
    input  logic            mc_start,
    input  logic [MC_W-1:0] mc_len,
    input  logic            load_use,
    input  logic            redirect_req,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            stallF,
    output logic            stallD,
    output logic            stallE,
    output logic            stallM,
    output logic            flushD,
    output logic            flushE,
    output logic            flushM,
    output logic            pc_sel,
    output logic [PC_W-1:0] pc_target
`ifdef HAZARD_PERF_EN
    ,
    output logic [63:0]     perf_stall_cyc,
    output logic [63:0]     perf_flush_cnt
`endif
);

    typedef enum logic {
        IDLE,
        DWAIT
    } memState_t;

    memState_t       state;
    memState_t       stateNext;
    logic [MC_W-1:0] mcCnt;
    logic            pendValid;
    logic [PC_W-1:0] pendPc;

    logic memStall;
    logic mcBusy;
    logic pendFire;

    // The first cycle of a missing response already stalls; in DWAIT the
    // response cycle itself releases the pipe.
    always_comb begin
        memStall = 1'b0;
        unique case (state)
            IDLE:    memStall = dreq_valid & ~dresp_ok;
            DWAIT:   memStall = ~dresp_ok;
            default: memStall = 1'b0;
        endcase
    end

    assign mcBusy = (mcCnt != '0);

    // A latched redirect waits for fetch to go idle and for the pipe to move;
    // a fresh redirect in the same cycle supersedes it.
    assign pendFire = pendValid & ~ireq_busy & ~memStall & ~mcBusy
                    & ~redirect_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (dreq_valid && !dresp_ok) stateNext = DWAIT;
            DWAIT:   if (dresp_ok) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        stallM    = 1'b0;
        flushD    = 1'b0;
        flushE    = 1'b0;
        flushM    = 1'b0;
        pc_sel    = 1'b0;
        pc_target = '0;
        if (reset) begin
            pc_target = '0;
        end else if (memStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushM = 1'b1;
        end else if (mcBusy) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
        end else if (redirect_req) begin
            flushD = 1'b1;
            flushE = 1'b1;
            if (!ireq_busy) begin
                pc_sel    = 1'b1;
                pc_target = redirect_pc;
            end
        end else if (pendFire) begin
            pc_sel    = 1'b1;
            pc_target = pendPc;
        end else if (load_use) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end else if (ireq_busy) begin
            stallF = 1'b1;
            flushD = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcCnt     <= '0;
            pendValid <= 1'b0;
            pendPc    <= '0;
        end else if (!memStall) begin
            // mc_start is only sampled once EX is free and memory is not
            // holding the pipe, so a start held through DWAIT lands here.
            if (mcBusy) begin
                mcCnt <= mcCnt - MC_W'(1);
            end else if (mc_start && mc_len > MC_W'(1)) begin
                mcCnt <= mc_len - MC_W'(1);
            end
            if (!mcBusy) begin
                if (redirect_req) begin
                    pendValid <= ireq_busy;
                    if (ireq_busy) begin
                        pendPc <= redirect_pc;
                    end
                end else if (pendFire) begin
                    pendValid <= 1'b0;
                end
            end
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cyc <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stallF) perf_stall_cyc <= perf_stall_cyc + 64'd1;
            if (flushE) perf_flush_cnt <= perf_flush_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector table plus a long multi-cycle sequence
// for hazard_ctrl.
module tb_hazard_ctrl;

    localparam logic [6:0] RST = 7'b1000000;
    localparam logic [6:0] IB  = 7'b0100000;
    localparam logic [6:0] DV  = 7'b0010000;
    localparam logic [6:0] OK  = 7'b0001000;
    localparam logic [6:0] MS  = 7'b0000100;
    localparam logic [6:0] LU  = 7'b0000010;
    localparam logic [6:0] RR  = 7'b0000001;
    localparam logic [6:0] NONE = 7'b0000000;

    localparam logic [7:0] SF = 8'h80;
    localparam logic [7:0] SD = 8'h40;
    localparam logic [7:0] SE = 8'h20;
    localparam logic [7:0] SM = 8'h10;
    localparam logic [7:0] FD = 8'h08;
    localparam logic [7:0] FE = 8'h04;
    localparam logic [7:0] FM = 8'h02;
    localparam logic [7:0] PS = 8'h01;
    localparam logic [7:0] Z8 = 8'h00;
    localparam logic [7:0] MEMS = SF | SD | SE | SM | FM;
    localparam logic [7:0] MCS  = SF | SD | SE | FM;
    localparam logic [7:0] BUSY = SF | FD;
    localparam logic [7:0] LUS  = SF | SD | FE;

    localparam logic [63:0] T1 = 64'h8000_1000;
    localparam logic [63:0] T2 = 64'h8000_2000;
    localparam logic [63:0] T3 = 64'h8000_3000;
    localparam logic [63:0] T4 = 64'h8000_4000;
    localparam logic [63:0] T5 = 64'h8000_5000;

    typedef struct {
        string       name;
        logic [6:0]  in;
        logic [5:0]  ml;
        logic [63:0] rpc;
        logic [7:0]  ex;
        logic [63:0] et;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        ireq_busy;
    logic        dreq_valid;
    logic        dresp_ok;
    logic        mc_start;
    logic [5:0]  mc_len;
    logic        load_use;
    logic        redirect_req;
    logic [63:0] redirect_pc;
    logic        stallF, stallD, stallE, stallM;
    logic        flushD, flushE, flushM;
    logic        pc_sel;
    logic [63:0] pc_target;
`ifdef HAZARD_PERF_EN
    logic [63:0] perf_stall_cyc;
    logic [63:0] perf_flush_cnt;
    logic [63:0] expStall;
    logic [63:0] expFlush;
`endif

    vec_t tbl[$];
    int   total;
    int   bad;

    hazard_ctrl #(.PC_W(64), .MC_W(6)) dut (
        .clk(clk),
        .reset(reset),
        .ireq_busy(ireq_busy),
        .dreq_valid(dreq_valid),
        .dresp_ok(dresp_ok),
        .mc_start(mc_start),
        .mc_len(mc_len),
        .load_use(load_use),
        .redirect_req(redirect_req),
        .redirect_pc(redirect_pc),
        .stallF(stallF),
        .stallD(stallD),
        .stallE(stallE),
        .stallM(stallM),
        .flushD(flushD),
        .flushE(flushE),
        .flushM(flushM),
        .pc_sel(pc_sel),
        .pc_target(pc_target)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cyc(perf_stall_cyc),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addv(input string n, input logic [6:0] in,
                        input logic [5:0] ml, input logic [63:0] rpc,
                        input logic [7:0] ex, input logic [63:0] et);
        vec_t v;
        v.name = n;
        v.in   = in;
        v.ml   = ml;
        v.rpc  = rpc;
        v.ex   = ex;
        v.et   = et;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic [6:0] in, input logic [5:0] ml,
                         input logic [63:0] rpc);
        {reset, ireq_busy, dreq_valid, dresp_ok,
         mc_start, load_use, redirect_req} = in;
        mc_len      = ml;
        redirect_pc = rpc;
    endtask

    function automatic logic [7:0] outs();
        return {stallF, stallD, stallE, stallM,
                flushD, flushE, flushM, pc_sel};
    endfunction

    initial begin
        int n;
        total = 0;
        bad   = 0;
`ifdef HAZARD_PERF_EN
        expStall = '0;
        expFlush = '0;
`endif
        drive(NONE, 6'd0, 64'd0);

        addv("rst",        RST,           0, 0,  Z8,        0);
        addv("rst_busy",   RST | IB | DV, 0, 0,  Z8,        0);
        addv("idle",       NONE,          0, 0,  Z8,        0);
        addv("dmiss0",     DV,            0, 0,  MEMS,      0);
        addv("dwait1",     DV,            0, 0,  MEMS,      0);
        addv("dwait2",     DV,            0, 0,  MEMS,      0);
        addv("dresp",      DV | OK,       0, 0,  Z8,        0);
        addv("dhit",       DV | OK,       0, 0,  Z8,        0);
        addv("idle2",      NONE,          0, 0,  Z8,        0);
        addv("mc5_start",  MS,            5, 0,  Z8,        0);
        addv("mc5_s1",     NONE,          0, 0,  MCS,       0);
        addv("mc5_s2",     NONE,          0, 0,  MCS,       0);
        addv("mc5_s3",     NONE,          0, 0,  MCS,       0);
        addv("mc5_s4",     NONE,          0, 0,  MCS,       0);
        addv("mc5_done",   NONE,          0, 0,  Z8,        0);
        addv("mc1_start",  MS,            1, 0,  Z8,        0);
        addv("mc1_after",  NONE,          0, 0,  Z8,        0);
        addv("mc0_start",  MS,            0, 0,  Z8,        0);
        addv("mc0_after",  NONE,          0, 0,  Z8,        0);
        addv("redir",      RR,            0, T1, FD|FE|PS,  T1);
        addv("redir_aft",  NONE,          0, 0,  Z8,        0);
        addv("rbusy",      RR | IB,       0, T1, FD|FE,     0);
        addv("rbusy_w1",   IB,            0, 0,  BUSY,      0);
        addv("rbusy_w2",   IB,            0, 0,  BUSY,      0);
        addv("rpend_fire", NONE,          0, 0,  PS,        T1);
        addv("rpend_clr",  NONE,          0, 0,  Z8,        0);
        addv("rov_a",      RR | IB,       0, T1, FD|FE,     0);
        addv("rov_b",      RR | IB,       0, T2, FD|FE,     0);
        addv("rov_w",      IB,            0, 0,  BUSY,      0);
        addv("rov_fire",   NONE,          0, 0,  PS,        T2);
        addv("rov_clr",    NONE,          0, 0,  Z8,        0);
        addv("lu_redir",   LU | RR,       0, T3, FD|FE|PS,  T3);
        addv("lu_only",    LU,            0, 0,  LUS,       0);
        addv("busy_only",  IB,            0, 0,  BUSY,      0);
        addv("rdw_miss",   DV,            0, 0,  MEMS,      0);
        addv("rdw_redir",  DV | RR,       0, T4, MEMS,      0);
        addv("rdw_resp",   DV | OK,       0, 0,  Z8,        0);
        addv("rdw_nopend", NONE,          0, 0,  Z8,        0);
        addv("mdw_miss",   DV | MS,       3, 0,  MEMS,      0);
        addv("mdw_wait",   DV | MS,       3, 0,  MEMS,      0);
        addv("mdw_resp",   DV | OK | MS,  3, 0,  Z8,        0);
        addv("mdw_s1",     NONE,          0, 0,  MCS,       0);
        addv("mdw_s2",     NONE,          0, 0,  MCS,       0);
        addv("mdw_done",   NONE,          0, 0,  Z8,        0);
        addv("rs_pend",    RR | IB,       0, T5, FD|FE,     0);
        addv("rs_mc4",     IB | MS,       4, 0,  BUSY,      0);
        addv("rs_dwait",   IB | DV,       0, 0,  MEMS,      0);
        addv("rs_reset",   RST | IB | DV, 0, 0,  Z8,        0);
        addv("rs_after",   NONE,          0, 0,  Z8,        0);
        addv("rs_nofire",  NONE,          0, 0,  Z8,        0);
        addv("rs_lateok",  DV | OK,       0, 0,  Z8,        0);

        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            drive(tbl[i].in, tbl[i].ml, tbl[i].rpc);
            @(negedge clk);
            total++;
            if (outs() !== tbl[i].ex) begin
                bad++;
                $display("FAIL %s: outs=%b want %b",
                         tbl[i].name, outs(), tbl[i].ex);
            end
            total++;
            if (pc_target !== tbl[i].et) begin
                bad++;
                $display("FAIL %s_tgt: pc_target=%h want %h",
                         tbl[i].name, pc_target, tbl[i].et);
            end
`ifdef HAZARD_PERF_EN
            total++;
            if (perf_stall_cyc !== expStall || perf_flush_cnt !== expFlush) begin
                bad++;
                $display("FAIL %s_perf: stall=%0d flush=%0d want %0d %0d",
                         tbl[i].name, perf_stall_cyc, perf_flush_cnt,
                         expStall, expFlush);
            end
            if (tbl[i].in[6]) begin
                expStall = '0;
                expFlush = '0;
            end else begin
                if (tbl[i].ex[7]) expStall = expStall + 64'd1;
                if (tbl[i].ex[2]) expFlush = expFlush + 64'd1;
            end
`endif
            @(posedge clk);
            #1;
        end

        // Longest multi-cycle op: 63 EX cycles means 62 stall cycles.
        drive(MS, 6'd63, 64'd0);
        @(negedge clk);
        total++;
        if (stallE !== 1'b0) begin
            bad++;
            $display("FAIL mc63_first: stallE=%b want 0", stallE);
        end
        @(posedge clk);
        #1;
        drive(NONE, 6'd0, 64'd0);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (stallE !== 1'b1) break;
            n++;
            @(posedge clk);
            #1;
        end
        total++;
        if (n != 62) begin
            bad++;
            $display("FAIL mc63_len: stall cycles=%0d want 62", n);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if (outs() !== Z8) begin
            bad++;
            $display("FAIL mc63_done: outs=%b want %b", outs(), Z8);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Central stall/flush scheduler for the 5-stage pipeline. It sequences every inter-stage register: IF/ID, ID/EX, EX/MEM and MEM/WB. Inputs are the data-memory handshake, multi-cycle EX operations, load-use hazards, branch redirects and instruction-fetch busy. It decides each cycle which registers hold (stall) and which load a bubble (flush, clearing `valid` only), and it owns the PC redirect.

## Interface
- `PC_W`, 64, redirect target width
- `MC_W`, 6, multi-cycle length counter width
- `clk` in 1 pipeline clock
- `reset` in 1 synchronous, active-high; one clock, sampled on rising edge
- `ireq_busy` in 1 instruction fetch outstanding
- `dreq_valid` in 1 MEM stage holds a valid load/store request
- `dresp_ok` in 1 data memory response this cycle
- `mc_start` in 1 EX stage begins a multi-cycle op (div/rem)
- `mc_len` in MC_W total EX cycles for that op
- `load_use` in 1 ID instruction depends on load in EX
- `redirect_req` in 1 EX resolved mispredict/jump
- `redirect_pc` in PC_W redirect target
- `stallF`, `stallD`, `stallE`, `stallM` out 1 hold PC / IF-ID / ID-EX / EX-MEM
- `flushD`, `flushE`, `flushM` out 1 bubble into IF-ID / ID-EX / MEM-WB
- `pc_sel` out 1 PC loads `pc_target`
- `pc_target` out PC_W redirect address
- (`HAZARD_PERF_EN` only) `perf_stall_cyc`, `perf_flush_cnt` out 64 counters

## Operation
- **Memory FSM** (`IDLE`, `DWAIT`):
  - In `IDLE`, if `dreq_valid & ~dresp_ok`: stall now and go to `DWAIT`.
  - In `IDLE`, if `dreq_valid & dresp_ok`: no stall.
  - In `DWAIT`: `stallF/D/E/M=1`, `flushM=1` (WB must not retire twice).
  - In `DWAIT` with `dresp_ok`: stalls drop the same cycle and the FSM goes to `IDLE`.
- **Multi-cycle counter `mc_cnt`**:
  - On `mc_start` while memory is not stalling, load `mc_len-1` if `mc_len>1`, else leave at 0.
  - While `mc_cnt!=0`: `stallF/D/E=1`, `flushM=1`, decrement.
  - `mc_start` held during a memory stall is taken on the first non-stalled cycle.
- **Redirect**:
  - Effective only when there is no memory stall and `mc_cnt==0`.
  - If `ireq_busy=0`: `pc_sel=1`, `pc_target=redirect_pc`, `flushD=flushE=1`.
  - If `ireq_busy=1`: latch target in `pend_valid/pend_pc` and assert `flushD=flushE=1` now. Fire `pc_sel` with `pend_pc` on the first cycle `ireq_busy=0`, then clear pending.
  - A new redirect overwrites the pending one.
- **Load-use**: `stallF=stallD=1`, `flushE=1` for the cycle. Ignored if a redirect is effective in the same cycle (the dependent instruction is flushed anyway).
- **Fetch busy**: `ireq_busy` with no higher-priority event gives `stallF=1`, `flushD=1`.
- **Priority**: memory wait > multi-cycle > redirect > load-use > fetch busy. Lower-priority events are dropped except the latched redirect and `mc_start`.
- A stage is never both stalled and flushed: stall wins for D/E, and `flushM` is separate from `stallM`.

## Timing
- All outputs are combinational from inputs plus registered state (FSM, `mc_cnt`, `pend_*`). No added latency.
- Registered state updates on `posedge clk`.
- On reset:
  - State: FSM=`IDLE`, `mc_cnt=0`, `pend_valid=0`, `pend_pc=0`, perf counters 0.
  - Outputs in the reset cycle: all stall/flush/`pc_sel`=0, `pc_target=0`.
- Reset mid-`DWAIT` or mid-count returns to `IDLE`/0 next cycle. An outstanding response arriving after reset is ignored by this block.
- A `mc_len=N` op occupies EX for exactly N cycles: N-1 stall cycles.
- A pending redirect fires at the latest 1 cycle after `ireq_busy` falls, with no extra flush.

## Configuration
- `HAZARD_PERF_EN` defined:
  - `perf_stall_cyc` increments on every cycle with `stallF=1`.
  - `perf_flush_cnt` increments on every cycle with `flushE=1`.
  - Both wrap at 2^64 and reset to 0.
- Undefined: the perf ports and counters are absent. All other behaviour is identical.

## Test plan
- Load, `dresp_ok` delayed 3 cycles: FSM in `DWAIT`, 3 cycles of all four stalls plus `flushM`, release on response cycle. Same-cycle response gives 0 stalls.
- `mc_start` with `mc_len=5`: exactly 4 cycles of `stallF/D/E` and `flushM`. `mc_len=1` and `mc_len=0` give none.
- `redirect_req` with `redirect_pc=0x8000_1000`, `ireq_busy=0`: same-cycle `pc_sel=1`, target `0x8000_1000`, `flushD=flushE=1`.
- Same redirect with `ireq_busy` high 2 more cycles: flushes now, `pc_sel` with `0x8000_1000` on the cycle busy drops. A second redirect `0x8000_2000` while pending overrides.
- Priority: `load_use` with `redirect_req` gives redirect only. Redirect during `DWAIT` has no effect. `mc_start` during `DWAIT` is deferred, then runs its full count.
- Reset asserted in `DWAIT` with `mc_cnt=3` and pending redirect: next cycle all outputs 0. With `HAZARD_PERF_EN`, counters read 0 after reset and match stall/flush cycle counts from the scenarios above.
